mem_stage: RTL

- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Issues loads/stores to the data memory over a req/ready handshake and generates byte enables.
- Aligns and sign/zero-extends load data, selects writeback data, and registers the result for the WB stage.
- Asserts a stall back to the pipeline while an access is outstanding.

---
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory bus between mem_stage and the data memory
//
// Purpose: bundles the data-memory request/ready handshake.
// Signals:
//   dm_req    request, held high for the whole access
//   dm_we     write (store) when high
//   dm_addr   word address, bits [1:0] always 0
//   dm_wdata  store data, replicated across byte lanes
//   dm_be     byte enables
//   dm_rdata  read data, valid while dm_ready is high
//   dm_ready  access completes this cycle
// Modports: master = mem_stage side, slave = memory side.

interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ready
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with data-memory handshake

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  rd_in,
    input  logic [31:0] ALU_Result_in,
    input  logic [31:0] rs2_value_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  DMType_in,
    input  logic [1:0]  WDSel_in,
    input  logic [31:0] pc_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
`ifdef MEM_TIMEOUT_EN
    output logic        bus_err,
`endif
    output logic        misalign_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  lane_q, wdsel_q;
    logic [3:0]  be_q;
    logic        we_q, regwrite_q;
    logic [2:0]  dmtype_q;
    logic [4:0]  rd_q;

    logic        is_access, is_half, is_byte, is_word, misaligned, start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_data, idle_wb_data, access_wb_data;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic        stall_c, timeout_hit;

    assign is_access  = in_valid & (MemWrite_in | (WDSel_in == 2'b01));
    assign is_half    = (DMType_in == 3'b001) | (DMType_in == 3'b010);
    assign is_byte    = (DMType_in == 3'b011) | (DMType_in == 3'b100);
    assign is_word    = ~is_half & ~is_byte;
    assign misaligned = (is_word & (|ALU_Result_in[1:0])) | (is_half & ALU_Result_in[0]);
    assign start      = is_access & ~misaligned;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = rs2_value_in;
        if (MemWrite_in && is_half) begin
            be_d    = 4'b0011 << {ALU_Result_in[1], 1'b0};
            wdata_d = {2{rs2_value_in[15:0]}};
        end else if (MemWrite_in && is_byte) begin
            be_d    = 4'b0001 << ALU_Result_in[1:0];
            wdata_d = {4{rs2_value_in[7:0]}};
        end
    end

    assign half_lane = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        byte_lane = dm_rdata[7:0];
        case (lane_q)
            2'd1:    byte_lane = dm_rdata[15:8];
            2'd2:    byte_lane = dm_rdata[23:16];
            2'd3:    byte_lane = dm_rdata[31:24];
            default: byte_lane = dm_rdata[7:0];
        endcase
    end

    always_comb begin
        load_data = dm_rdata;
        case (dmtype_q)
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b010:  load_data = {16'd0, half_lane};
            3'b011:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_data = {24'd0, byte_lane};
            default: load_data = dm_rdata;
        endcase
    end

    assign idle_wb_data   = (WDSel_in == 2'b10) ? pc_in + 32'd4 : ALU_Result_in;
    assign access_wb_data = (wdsel_q == 2'b01) ? load_data :
                            (wdsel_q == 2'b10) ? pc_in + 32'd4 : ALU_Result_in;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout_hit = (state_q == ACCESS) & ~dm_ready &
                         (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= 8'd0;
        else if (state_q == IDLE)
            to_cnt <= 8'd0;
        else if (!dm_ready)
            to_cnt <= to_cnt + 8'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                    stall_c = 1'b1;
                end
            end
            ACCESS: begin
                stall_c = ~dm_ready & ~timeout_hit;
                if (dm_ready || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = rst & stall_c;

    assign dm_req   = (state_q == ACCESS);
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign dm_be    = be_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            lane_q       <= '0;
            wdsel_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            regwrite_q   <= 1'b0;
            dmtype_q     <= '0;
            rd_q         <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err      <= 1'b0;
`endif
        end else begin
            misalign_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= {ALU_Result_in[31:2], 2'b00};
                        lane_q      <= ALU_Result_in[1:0];
                        we_q        <= MemWrite_in;
                        be_q        <= be_d;
                        wdata_q     <= wdata_d;
                        dmtype_q    <= DMType_in;
                        rd_q        <= rd_in;
                        regwrite_q  <= RegWrite_in;
                        wdsel_q     <= WDSel_in;
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end else if (in_valid) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_in;
                        wb_data      <= idle_wb_data;
                        wb_regwrite  <= RegWrite_in & ~is_access;
                        misalign_err <= is_access;
                    end else begin
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dm_ready) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd_q;
                        wb_regwrite <= regwrite_q;
                        wb_data     <= access_wb_data;
                    end else if (timeout_hit) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd_q;
                        wb_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        bus_err     <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
